// File: rtl/bingo_pkg.sv
// bingo_pkg: shared opcodes, directions, FSM states and board geometry for the bingo map writer
package bingo_pkg;
  localparam int BOARD_N = 5;
  localparam int CELL_W = 5;
  localparam int CELLS = BOARD_N * BOARD_N;
  localparam logic [1:0] OP_MOVE = 2'd0;
  localparam logic [1:0] OP_PLACE = 2'd1;
  localparam logic [1:0] OP_MARK = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;
  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;
endpackage

// File: rtl/bingo_line_counter.sv
// bingo_line_counter: combinational count of all-zero rows, columns and diagonals of the board
module bingo_line_counter
  import bingo_pkg::*;
(
  input  logic [BOARD_N*BOARD_N*CELL_W-1:0] map,
  output logic [3:0]                        count
);
  logic [BOARD_N-1:0][BOARD_N-1:0] zc;
  logic [BOARD_N-1:0] rz, cz;
  logic [1:0] dz;
  for (genvar y = 0; y < BOARD_N; y++) begin : g_row
    for (genvar x = 0; x < BOARD_N; x++) begin : g_col
      assign zc[y][x] = map[CELL_W*(x+BOARD_N*y) +: CELL_W] == '0;
    end
  end
  always_comb begin
    rz = '0;
    cz = '1;
    dz = 2'b11;
    count = '0;
    for (int i = 0; i < BOARD_N; i++) begin
      rz[i] = &zc[i];
      for (int j = 0; j < BOARD_N; j++) cz[i] = cz[i] & zc[j][i];
      dz[0] = dz[0] & zc[i][i];
      dz[1] = dz[1] & zc[i][BOARD_N-1-i];
    end
    for (int i = 0; i < BOARD_N; i++) count = count + 4'(rz[i]) + 4'(cz[i]);
    count = count + 4'(dz[0]) + 4'(dz[1]);
  end
endmodule

// File: rtl/board_map_writer.sv
// board_map_writer: bingo board setup (PLACE/MOVE) and play (MARK scan) engine.
// Define BINGO_LINE_COUNT_EN to report completed lines after each MARK; otherwise lines is 0.
module board_map_writer #(
  parameter int BOARD_N = bingo_pkg::BOARD_N,
  parameter int CELL_W = bingo_pkg::CELL_W
) (
  input  logic                              clk_25MHz,
  input  logic                              all_rst,
  input  logic                              cmd_valid,
  input  logic [1:0]                        cmd_op,
  input  logic [1:0]                        cmd_dir,
  input  logic [4:0]                        cmd_num,
  output logic                              cmd_ready,
  output logic [BOARD_N*BOARD_N*CELL_W-1:0] map,
  output logic [2:0]                        cursor_x,
  output logic [2:0]                        cursor_y,
  output logic                              phase_play,
  output logic                              mark_done,
  output logic                              mark_found,
  output logic [3:0]                        lines
);
  import bingo_pkg::*;
  localparam int NC = BOARD_N * BOARD_N;
  localparam int IW = $clog2(NC);
  localparam logic [2:0] LAST = 3'(BOARD_N - 1);
  state_t state;
  logic [CELL_W-1:0] cells [NC];
  logic [CELL_W-1:0] next_val, num, cur_cell;
  logic [IW-1:0] idx, cur_idx;
  logic [2:0] mv_x, mv_y, adv_x, adv_y;
  logic found, hit;
  for (genvar g = 0; g < NC; g++) begin : g_map
    assign map[CELL_W*g +: CELL_W] = cells[g];
  end
  always_comb begin
    cur_idx = IW'(cursor_x) + IW'(cursor_y) * IW'(BOARD_N);
    cur_cell = cells[cur_idx];
    hit = num != '0 && cells[idx] == num;
    mv_x = cmd_dir == DIR_LEFT ? (cursor_x == '0 ? LAST : cursor_x - 3'd1) :
           cmd_dir == DIR_RIGHT ? (cursor_x == LAST ? '0 : cursor_x + 3'd1) : cursor_x;
    mv_y = cmd_dir == DIR_UP ? (cursor_y == '0 ? LAST : cursor_y - 3'd1) :
           cmd_dir == DIR_DOWN ? (cursor_y == LAST ? '0 : cursor_y + 3'd1) : cursor_y;
    adv_x = cursor_x == LAST ? '0 : cursor_x + 3'd1;
    adv_y = cursor_x != LAST ? cursor_y : cursor_y == LAST ? '0 : cursor_y + 3'd1;
  end
  always_ff @(posedge clk_25MHz) begin
    if (all_rst) begin
      state <= ST_IDLE;
      for (int i = 0; i < NC; i++) cells[i] <= '0;
      cursor_x <= '0;
      cursor_y <= '0;
      next_val <= CELL_W'(1);
      phase_play <= 1'b0;
      cmd_ready <= 1'b1;
      mark_done <= 1'b0;
      mark_found <= 1'b0;
      num <= '0;
      idx <= '0;
      found <= 1'b0;
    end else begin
      mark_done <= 1'b0;
      case (state)
        ST_IDLE: if (cmd_valid) begin
          case (cmd_op)
            OP_MOVE: begin
              cursor_x <= mv_x;
              cursor_y <= mv_y;
            end
            OP_PLACE: if (!phase_play && cur_cell == '0) begin
              cells[cur_idx] <= next_val;
              next_val <= next_val + CELL_W'(1);
              phase_play <= next_val == CELL_W'(NC);
              cursor_x <= adv_x;
              cursor_y <= adv_y;
            end
            OP_MARK: if (phase_play) begin
              state <= ST_SCAN;
              cmd_ready <= 1'b0;
              num <= CELL_W'(cmd_num);
              idx <= '0;
              found <= 1'b0;
            end
            default: begin
              for (int i = 0; i < NC; i++) cells[i] <= '0;
              next_val <= CELL_W'(1);
              cursor_x <= '0;
              cursor_y <= '0;
              phase_play <= 1'b0;
            end
          endcase
        end
        ST_SCAN: begin
          if (hit) cells[idx] <= '0;
          found <= found | hit;
          idx <= idx + IW'(1);
          if (idx == IW'(NC - 1)) begin
            state <= ST_DONE;
            mark_done <= 1'b1;
            mark_found <= found | hit;
          end
        end
        default: begin
          state <= ST_IDLE;
          cmd_ready <= 1'b1;
          mark_found <= 1'b0;
        end
      endcase
    end
  end
`ifdef BINGO_LINE_COUNT_EN
  logic [3:0] line_cnt;
  bingo_line_counter u_line_counter (.map(map), .count(line_cnt));
  // DONE is the first cycle the post-scan map is fully visible
  always_ff @(posedge clk_25MHz) begin
    if (all_rst) lines <= '0;
    else if (state == ST_DONE) lines <= line_cnt;
    else if (state == ST_IDLE && cmd_valid && cmd_op == OP_CLEAR) lines <= '0;
  end
`else
  assign lines = '0;
`endif
endmodule

// File: tb/tb_board_map_writer.sv
// tb_board_map_writer: directed scoreboard bench for board_map_writer
module tb_board_map_writer;
  localparam logic [1:0] MV = 2'd0, PL = 2'd1, MK = 2'd2, CL = 2'd3;
  localparam logic [1:0] UP = 2'd0, DN = 2'd1, LF = 2'd2, RT = 2'd3;
  logic clk_25MHz = 1'b0, all_rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0, cmd_dir = '0;
  logic [4:0] cmd_num = '0;
  logic cmd_ready, phase_play, mark_done, mark_found;
  logic [124:0] map;
  logic [2:0] cursor_x, cursor_y;
  logic [3:0] lines;
  typedef struct {logic found; logic [124:0] map;} exp_t;
  exp_t q[$];
  logic [4:0] m [25];
  int checks = 0, failures = 0, done_seen = 0, exp_dones = 0;
  logic [3:0] exp_l1, exp_l2;
  board_map_writer dut (
    .clk_25MHz(clk_25MHz), .all_rst(all_rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_dir(cmd_dir), .cmd_num(cmd_num), .cmd_ready(cmd_ready), .map(map),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .phase_play(phase_play),
    .mark_done(mark_done), .mark_found(mark_found), .lines(lines)
  );
  always #20 clk_25MHz = ~clk_25MHz;
  task automatic check(string name, logic [124:0] act, logic [124:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [124:0] pack();
    logic [124:0] p;
    for (int i = 0; i < 25; i++) p[5*i +: 5] = m[i];
    return p;
  endfunction
  always @(negedge clk_25MHz) begin
    if (mark_done) begin
      done_seen++;
      if (q.size() == 0) check("unexpected_done", {124'd0, mark_done}, 125'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("mark_found", {124'd0, mark_found}, {124'd0, e.found});
        check("mark_map", map, e.map);
      end
    end
  end
  task automatic send(logic [1:0] op, logic [1:0] dir, logic [4:0] num);
    @(negedge clk_25MHz);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_dir = dir;
    cmd_num = num;
    @(negedge clk_25MHz);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk_25MHz);
      n++;
    end
    check("ready_timeout", {124'd0, cmd_ready}, 125'd1);
  endtask
  task automatic do_mark(logic [4:0] num, logic exp_found);
    for (int i = 0; i < 25; i++) if (num != 0 && m[i] == num) m[i] = '0;
    q.push_back('{exp_found, pack()});
    exp_dones++;
    send(MK, UP, num);
    wait_ready();
  endtask
  task automatic check_cursor(string name, int x, int y);
    check(name, {119'd0, cursor_y, cursor_x}, {119'd0, 3'(y), 3'(x)});
  endtask
  initial begin
`ifdef BINGO_LINE_COUNT_EN
    exp_l1 = 4'd1;
    exp_l2 = 4'd2;
`else
    exp_l1 = 4'd0;
    exp_l2 = 4'd0;
`endif
    for (int i = 0; i < 25; i++) m[i] = '0;
    repeat (3) @(negedge clk_25MHz);
    all_rst = 1'b0;
    check("rst_map", map, 125'd0);
    check("rst_ready", {124'd0, cmd_ready}, 125'd1);
    check("rst_phase", {124'd0, phase_play}, 125'd0);
    check("rst_done", {123'd0, mark_done, mark_found}, 125'd0);
    check("rst_lines", {121'd0, lines}, 125'd0);
    check_cursor("rst_cursor", 0, 0);
    for (int i = 0; i < 25; i++) begin
      send(PL, UP, 5'd0);
      m[i] = 5'(i + 1);
      if (i == 2) begin
        send(MV, LF, 5'd0);
        send(PL, UP, 5'd0);
        check("place_nonzero_map", map, pack());
        check_cursor("place_nonzero_cursor", 2, 0);
        send(MK, UP, 5'd1);
        check("mark_setup_ready", {124'd0, cmd_ready}, 125'd1);
        check("mark_setup_map", map, pack());
        send(MV, RT, 5'd0);
      end
      if (i == 23) check("phase_before_25", {124'd0, phase_play}, 125'd0);
    end
    check("fill_map", map, pack());
    check("fill_phase", {124'd0, phase_play}, 125'd1);
    check_cursor("fill_cursor", 0, 0);
    send(MV, LF, 5'd0);
    check_cursor("move_left_wrap", 4, 0);
    send(MV, UP, 5'd0);
    check_cursor("move_up_wrap", 4, 4);
    send(MV, DN, 5'd0);
    check_cursor("move_down_wrap", 4, 0);
    send(MV, RT, 5'd0);
    check_cursor("move_right_wrap", 0, 0);
    m[12] = '0;
    q.push_back('{1'b1, pack()});
    exp_dones++;
    send(MK, UP, 5'd13);
    repeat (12) @(negedge clk_25MHz);
    check("cell22_t13", {120'd0, map[60 +: 5]}, 125'd13);
    @(negedge clk_25MHz);
    check("cell22_t14", {120'd0, map[60 +: 5]}, 125'd0);
    repeat (11) @(negedge clk_25MHz);
    check("done_t25", {124'd0, mark_done}, 125'd0);
    @(negedge clk_25MHz);
    check("done_t26", {124'd0, mark_done}, 125'd1);
    check("ready_t26", {124'd0, cmd_ready}, 125'd0);
    @(negedge clk_25MHz);
    check("ready_t27", {124'd0, cmd_ready}, 125'd1);
    do_mark(5'd30, 1'b0);
    do_mark(5'd13, 1'b0);
    for (int n = 1; n <= 5; n++) do_mark(5'(n), 1'b1);
    check("lines_row", {121'd0, lines}, {121'd0, exp_l1});
    do_mark(5'd7, 1'b1);
    do_mark(5'd13, 1'b0);
    do_mark(5'd19, 1'b1);
    do_mark(5'd25, 1'b1);
    check("lines_diag", {121'd0, lines}, {121'd0, exp_l2});
    send(MK, UP, 5'd20);
    repeat (9) @(negedge clk_25MHz);
    all_rst = 1'b1;
    @(negedge clk_25MHz);
    all_rst = 1'b0;
    for (int i = 0; i < 25; i++) m[i] = '0;
    check("abort_map", map, 125'd0);
    check("abort_ready", {124'd0, cmd_ready}, 125'd1);
    check("abort_done", {124'd0, mark_done}, 125'd0);
    check("abort_phase", {124'd0, phase_play}, 125'd0);
    check("abort_lines", {121'd0, lines}, 125'd0);
    repeat (30) @(negedge clk_25MHz);
    check("done_count", 125'(done_seen), 125'(exp_dones));
    send(PL, UP, 5'd0);
    send(PL, UP, 5'd0);
    send(CL, UP, 5'd0);
    check("clear_map", map, 125'd0);
    check_cursor("clear_cursor", 0, 0);
    send(PL, UP, 5'd0);
    m[0] = 5'd1;
    check("clear_next_val", map, pack());
    check_cursor("clear_place_cursor", 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
